// File: rtl/multiplicador_booth_param.sv
// Sequential radix-2 Booth multiplier with a parameterised width and run-time signed/unsigned mode.
// One iteration per clock. The datapath and the control FSM are in this one block.
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   start             request; accepted in IDLE or FIN, ignored while OPERA
//   signo             1 = two's-complement operands, 0 = unsigned (latched on accept)
//   Mcando, Mcador    multiplicand / multiplier, sampled on the accept edge
//   producto          registered 2*WIDTH product
//   fin               result valid (level, held until next accept)
//   busy              operation in progress
module multiplicador_booth_param #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signo,
   input  logic [WIDTH-1:0]     Mcando,
   input  logic [WIDTH-1:0]     Mcador,
   output logic [2*WIDTH-1:0]   producto,
   output logic                 fin,
   output logic                 busy
);

   localparam int unsigned AW = WIDTH + 2;   // accumulator: absorbs -2^(W-1) and 2^W-1 magnitudes
   localparam int unsigned QW = WIDTH + 1;   // extended operand width
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 2);

   typedef enum logic [1:0] {IDLE, OPERA, FIN} state_t;

   state_t          state, state_n;
   logic [AW-1:0]   a, a_n, a_sum;
   logic [QW-1:0]   q, q_n;
   logic [QW-1:0]   m, m_n;
   logic            q1, q1_n;
   logic            sig, sig_n;
   logic [CW-1:0]   count, count_n;
   logic [PW-1:0]   producto_n;
   logic            fin_n, busy_n;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         a        <= '0;
         q        <= '0;
         m        <= '0;
         q1       <= 1'b0;
         sig      <= 1'b0;
         count    <= '0;
         producto <= '0;
         fin      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         a        <= a_n;
         q        <= q_n;
         m        <= m_n;
         q1       <= q1_n;
         sig      <= sig_n;
         count    <= count_n;
         producto <= producto_n;
         fin      <= fin_n;
         busy     <= busy_n;
      end
   end

   // Next-state, Booth iteration and completion
   always_comb begin
      state_n    = state;
      a_n        = a;
      q_n        = q;
      m_n        = m;
      q1_n       = q1;
      sig_n      = sig;
      count_n    = count;
      producto_n = producto;
      fin_n      = fin;
      busy_n     = busy;
      a_sum      = a;

      case (state)
         IDLE, FIN: begin
            if (start) begin
               m_n     = signo ? {Mcando[WIDTH-1], Mcando} : {1'b0, Mcando};
               q_n     = signo ? {Mcador[WIDTH-1], Mcador} : {1'b0, Mcador};
               a_n     = '0;
               q1_n    = 1'b0;
               sig_n   = signo;
               // unsigned needs one extra step to consume the zero extension bit
               count_n = signo ? CW'(WIDTH) : CW'(WIDTH + 1);
               fin_n   = 1'b0;
               busy_n  = 1'b1;
               state_n = OPERA;
            end
         end
         OPERA: begin
            if (count != '0) begin
               case ({q[0], q1})
                  2'b10:   a_sum = a - {m[QW-1], m};
                  2'b01:   a_sum = a + {m[QW-1], m};
                  default: a_sum = a;
               endcase
               a_n     = {a_sum[AW-1], a_sum[AW-1:1]};
               q_n     = {a_sum[0], q[QW-1:1]};
               q1_n    = q[0];
               count_n = count - CW'(1);
            end else begin
               // signed mode did one step fewer, so its product sits one bit higher
               producto_n = PW'({a, q} >> sig);
               fin_n      = 1'b1;
               busy_n     = 1'b0;
               state_n    = FIN;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
